// File: rtl/operand_shift_stage_if.sv
// Handshake and data bundle between the issue side, this operand stage and the ALU.
interface operand_shift_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rn_val;
  logic [31:0] rm_val;
  logic [31:0] rs_val;
  logic [3:0]  flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic        shifter_c;
  logic        cond_pass;
  logic [3:0]  rd;
  logic        s_bit;

  // Producer of instructions and consumer of the ALU bundle.
  modport master (
    output in_valid, instr, rn_val, rm_val, rs_val, flags, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_sel, shifter_c, cond_pass, rd, s_bit
  );

  // The operand stage itself.
  modport slave (
    input  in_valid, instr, rn_val, rm_val, rs_val, flags, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_sel, shifter_c, cond_pass, rd, s_bit
  );
endinterface

// File: rtl/operand_shift_stage.sv
// ARMv4 data-processing operand stage: condition check, barrel shifter and
// shifter carry, registered towards the ALU behind a valid/ready handshake.
module operand_shift_stage #(
  parameter bit REG_SHIFT_STALL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_shift_stage_if.slave bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT, ST_FULL} state_e;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_e;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic        shifter_c;
    logic        cond_pass;
    logic [3:0]  rd;
    logic        s_bit;
  } bundle_t;

  // Rotate right; n = 0 leaves the value unchanged because v << 32 is zero.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

  // Shift by a full 8-bit amount with ARM out-of-range rules; returns {carry, value}.
  function automatic logic [32:0] barrel(input shift_e typ, input logic [7:0] amt,
                                         input logic [31:0] rm, input logic c_in);
    logic [32:0]        t;
    logic signed [32:0] s;
    logic [31:0]        r;
    logic [32:0]        res;
    t   = '0;
    s   = '0;
    r   = '0;
    res = {c_in, rm};
    if (amt != 8'd0) begin
      case (typ)
        // Extra guard bit on the side the data leaves catches the carry.
        SH_LSL: begin
          t   = {1'b0, rm} << amt;
          res = t;
        end
        SH_LSR: begin
          t   = {rm, 1'b0} >> amt;
          res = {t[0], t[32:1]};
        end
        SH_ASR: begin
          s   = $signed({rm, 1'b0}) >>> amt;
          res = {s[0], s[32:1]};
        end
        default: begin
          r   = ror32(rm, amt[4:0]);
          res = {r[31], r};
        end
      endcase
    end
    return res;
  endfunction

  // Shifter operand for all three encodings; returns {carry, value}.
  function automatic logic [32:0] operand(input logic i_bit, input logic [11:0] sh,
                                          input logic [31:0] rm, input logic [7:0] rs,
                                          input logic c_in);
    logic [31:0] imm;
    shift_e      typ;
    logic [32:0] res;
    typ = shift_e'(sh[6:5]);
    imm = ror32({24'd0, sh[7:0]}, {sh[11:8], 1'b0});
    if (i_bit) begin
      res = {(sh[11:8] == 4'd0) ? c_in : imm[31], imm};
    end else if (sh[4]) begin
      res = barrel(typ, rs, rm, c_in);
    end else if (sh[11:7] != 5'd0) begin
      res = barrel(typ, {3'd0, sh[11:7]}, rm, c_in);
    end else begin
      // Zero immediate amounts encode LSL #0, LSR #32, ASR #32 and RRX.
      case (typ)
        SH_LSL:  res = {c_in, rm};
        SH_ROR:  res = {rm[0], c_in, rm[31:1]};
        default: res = barrel(typ, 8'd32, rm, c_in);
      endcase
    end
    return res;
  endfunction

  // Odd condition codes are the inverse of the even one below them; 1111 inverts AL.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  state_e      state_q, state_d;
  state_e      load_state;
  bundle_t     bundle_q, bundle_d;
  logic [32:0] shift_res;
  logic        in_ready;
  logic        out_valid;
  logic        accept;
  logic        unused_bits;

  assign unused_bits = ^{bus.rs_val[31:8], bus.instr[27:26], bus.instr[19:16]};

  // Register-specified shifts optionally take an extra cycle in SHIFT.
  assign load_state = (REG_SHIFT_STALL && !bus.instr[25] && bus.instr[4]) ? ST_SHIFT : ST_FULL;

  // Bundle computed from the inputs presented this cycle; captured only on accept.
  always_comb begin
    shift_res          = operand(bus.instr[25], bus.instr[11:0], bus.rm_val,
                                 bus.rs_val[7:0], bus.flags[1]);
    bundle_d.alu_a     = bus.rn_val;
    bundle_d.alu_b     = shift_res[31:0];
    bundle_d.alu_sel   = bus.instr[24:21];
    bundle_d.shifter_c = shift_res[32];
    bundle_d.cond_pass = cond_ok(bus.instr[31:28], bus.flags);
    bundle_d.rd        = bus.instr[15:12];
    bundle_d.s_bit     = bus.instr[20];
  end

  // Handshake outputs and next state; in_ready never looks at in_valid.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
      end
      default: ;
    endcase
    accept = bus.in_valid && in_ready;
    case (state_q)
      ST_EMPTY: if (accept) state_d = load_state;
      ST_SHIFT: state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready) state_d = accept ? load_state : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Output bundle register, loaded on accept and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is reset too because the ALU-facing outputs must read zero out of reset.
    if (!rst_n)      bundle_q <= '0;
    else if (accept) bundle_q <= bundle_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_a     = bundle_q.alu_a;
  assign bus.alu_b     = bundle_q.alu_b;
  assign bus.alu_sel   = bundle_q.alu_sel;
  assign bus.shifter_c = bundle_q.shifter_c;
  assign bus.cond_pass = bundle_q.cond_pass;
  assign bus.rd        = bundle_q.rd;
  assign bus.s_bit     = bundle_q.s_bit;

endmodule
